// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// FSM states and the control vector produced by the decoder.
package uc_pkg;

  // Instruction opcodes (low three bits of op_code)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_LD  = 3'b100;

  // ALU operation codes, zero-extended to ALUW at the top level
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } st_e;

  typedef struct packed {
    logic       wEnable_BR;
    logic       SEL_dmx;
    logic [3:0] OP_alu;
    logic       W_ram;
    logic       R_ram;
  } ctrl_t;

  // Datapath-idle control vector: nothing written, ALU parked on NOP
  localparam ctrl_t CTRL_DEFAULT = '{wEnable_BR: 1'b0, SEL_dmx: 1'b1,
                                     OP_alu: ALU_NOP, W_ram: 1'b0, R_ram: 1'b0};

  // ALU code for the three register-to-register operations
  function automatic logic [3:0] alu_code(input logic [2:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_SLT:  alu_code = ALU_SLT;
      default: alu_code = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/unidad_control_mc_if.sv
// Bundle of instruction handshake, RAM acknowledge and datapath control lines.
// The control unit uses the slave modport; the instruction source/datapath
// side uses the master modport.
interface unidad_control_mc_if #(
  parameter int OPW  = 3,
  parameter int ALUW = 4
) ();

  logic            instr_valid;
  logic            instr_ready;
  logic [OPW-1:0]  op_code;
  logic            mem_ack;
  logic            wEnable_BR;
  logic            SEL_dmx;
  logic [ALUW-1:0] OP_alu;
  logic            W_ram;
  logic            R_ram;
  logic            busy;
  logic            illegal_op;
  logic            mem_err;

  modport master (
    output instr_valid, op_code, mem_ack,
    input  instr_ready, wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram,
           busy, illegal_op, mem_err
  );

  modport slave (
    input  instr_valid, op_code, mem_ack,
    output instr_ready, wEnable_BR, SEL_dmx, OP_alu, W_ram, R_ram,
           busy, illegal_op, mem_err
  );

endinterface

// File: rtl/uc_decode.sv
// Combinational decoder: maps the current state and latched opcode to the
// datapath control vector, plus legality / memory / load classification.
module uc_decode
  import uc_pkg::*;
#(
  parameter int OPW = 3
) (
  input  st_e            state,
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl,
  output logic           is_legal,
  output logic           is_mem,
  output logic           is_load
);

  logic [2:0] op3;
  logic       is_alu;

  // Any code above LD is illegal, including codes with upper bits set
  assign op3      = opcode[2:0];
  assign is_legal = (opcode <= OPW'(OP_LD));
  assign is_mem   = is_legal && ((op3 == OP_ST) || (op3 == OP_LD));
  assign is_load  = is_legal && (op3 == OP_LD);
  assign is_alu   = is_legal && !is_mem;

  // Per-state control vector; IDLE and DECODE keep the datapath parked
  always_comb begin
    ctrl = CTRL_DEFAULT;
    case (state)
      ST_EXEC: begin
        if (is_alu) begin
          ctrl.OP_alu  = alu_code(op3);
          ctrl.SEL_dmx = 1'b0;
        end else if (is_mem) begin
          ctrl.OP_alu  = ALU_ADD;
          ctrl.SEL_dmx = 1'b1;
        end
      end
      ST_MEM: begin
        if (is_mem) begin
          ctrl.OP_alu  = ALU_ADD;
          ctrl.SEL_dmx = 1'b1;
          ctrl.W_ram   = !is_load;
          ctrl.R_ram   = is_load;
        end
      end
      ST_WB: begin
        if (is_load) begin
          ctrl.wEnable_BR = 1'b1;
          ctrl.SEL_dmx    = 1'b1;
          ctrl.OP_alu     = ALU_NOP;
        end else if (is_alu) begin
          ctrl.wEnable_BR = 1'b1;
          ctrl.SEL_dmx    = 1'b0;
          ctrl.OP_alu     = alu_code(op3);
        end
      end
      default: ctrl = CTRL_DEFAULT;
    endcase
  end

endmodule

// File: rtl/unidad_control_mc.sv
// Multi-cycle control unit: accepts one opcode per valid/ready handshake and
// steps through DECODE/EXEC/MEM/WB, driving register-file, ALU and RAM
// controls as Moore outputs.
// Optional: define UC_TIMEOUT_EN to abort a RAM access that is not
// acknowledged within MEM_TIMEOUT cycles (pulses mem_err).
module unidad_control_mc
  import uc_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int ALUW        = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  unidad_control_mc_if.slave bus
);

  st_e            state_q, state_d;
  logic [OPW-1:0] opcode_q;
  logic           illegal_q;
  ctrl_t          ctrl;
  logic           is_legal;
  logic           is_mem;
  logic           is_load;
  logic           timeout_hit;

  uc_decode #(.OPW(OPW)) u_decode (
    .state    (state_q),
    .opcode   (opcode_q),
    .ctrl     (ctrl),
    .is_legal (is_legal),
    .is_mem   (is_mem),
    .is_load  (is_load)
  );

`ifdef UC_TIMEOUT_EN
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;
  logic          mem_err_q;

  // Timeout fires on the MEM cycle whose missed ack would bring the count to
  // MEM_TIMEOUT; an ack in that same cycle takes priority
  assign timeout_hit = (state_q == ST_MEM) && !bus.mem_ack &&
                       (tmo_cnt == CW'(MEM_TIMEOUT - 1));

  // Count un-acknowledged MEM cycles, cleared on the way into MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) begin
        tmo_cnt <= '0;
      end else if ((state_q == ST_MEM) && !bus.mem_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      mem_err_q <= timeout_hit;
    end
  end

  assign bus.mem_err = mem_err_q;
`else
  logic unused_timeout;

  // MEM_TIMEOUT has no effect when the RAM wait is unbounded
  assign unused_timeout = |MEM_TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.mem_err    = 1'b0;
`endif

  // State, latched opcode and the one-cycle illegal-opcode flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && bus.instr_valid) begin
        opcode_q <= bus.op_code;
      end
      illegal_q <= (state_q == ST_DECODE) && !is_legal;
    end
  end

  // Next-state sequencing; instr_valid and mem_ack only matter in IDLE / MEM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = is_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC:   state_d = is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_d = is_load ? ST_WB : ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.illegal_op  = illegal_q;
  assign bus.wEnable_BR  = ctrl.wEnable_BR;
  assign bus.SEL_dmx     = ctrl.SEL_dmx;
  assign bus.OP_alu      = ALUW'(ctrl.OP_alu);
  assign bus.W_ram       = ctrl.W_ram;
  assign bus.R_ram       = ctrl.R_ram;

endmodule

// File: tb/tb_unidad_control_mc.sv
// Directed testbench for unidad_control_mc: ALU ops, LD/ST with delayed acks,
// illegal opcode, asynchronous reset mid-access and (with UC_TIMEOUT_EN)
// the RAM timeout path.
module tb_unidad_control_mc;

  localparam int TB_TIMEOUT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  unidad_control_mc_if #(.OPW(3), .ALUW(4)) bus ();

  unidad_control_mc #(.OPW(3), .ALUW(4), .MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full output vector check; busy is always the inverse of instr_ready
  task automatic expectCtrl(input string tag, input logic wen, input logic sel,
                            input logic [3:0] alu, input logic w, input logic r,
                            input logic rdy, input logic ill, input logic merr);
    checkOutput({tag, ".wEnable_BR"}, 32'(bus.wEnable_BR), 32'(wen));
    checkOutput({tag, ".SEL_dmx"},    32'(bus.SEL_dmx),    32'(sel));
    checkOutput({tag, ".OP_alu"},     32'(bus.OP_alu),     32'(alu));
    checkOutput({tag, ".W_ram"},      32'(bus.W_ram),      32'(w));
    checkOutput({tag, ".R_ram"},      32'(bus.R_ram),      32'(r));
    checkOutput({tag, ".instr_ready"}, 32'(bus.instr_ready), 32'(rdy));
    checkOutput({tag, ".busy"},       32'(bus.busy),       32'(!rdy));
    checkOutput({tag, ".illegal_op"}, 32'(bus.illegal_op), 32'(ill));
    checkOutput({tag, ".mem_err"},    32'(bus.mem_err),    32'(merr));
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic ack);
    bus.instr_valid = valid;
    bus.op_code     = op;
    bus.mem_ack     = ack;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One register-to-register op; op_code is scrambled while busy to show it is latched
  task automatic runAluOp(input string tag, input logic [2:0] op,
                          input logic [3:0] alu);
    applyStimulus(1'b1, op, 1'b0);
    stepClk();
    applyStimulus(1'b0, 3'b100, 1'b0);
    expectCtrl({tag, "_decode"}, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl({tag, "_exec"},   1'b0, 1'b0, alu,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl({tag, "_wb"},     1'b1, 1'b0, alu,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl({tag, "_idle"},   1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 3'b000, 1'b0);

    #3;
    expectCtrl("reset", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #9 rst_n = 1'b1;
    stepClk();

    runAluOp("add", 3'b000, 4'b0010);
    runAluOp("sub", 3'b001, 4'b0110);
    runAluOp("slt", 3'b010, 4'b0111);

    // LD with mem_ack arriving in the 4th MEM cycle
    applyStimulus(1'b1, 3'b100, 1'b0);
    stepClk();
    applyStimulus(1'b0, 3'b000, 1'b0);
    expectCtrl("ld_decode", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl("ld_exec",   1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    for (int i = 0; i < 4; i++) begin
      expectCtrl($sformatf("ld_mem%0d", i), 1'b0, 1'b1, 4'h2, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0);
      if (i == 3) bus.mem_ack = 1'b1;
      stepClk();
    end
    bus.mem_ack = 1'b0;
    expectCtrl("ld_wb",   1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl("ld_idle", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // ST with an early ack during EXEC, which must be ignored
    applyStimulus(1'b1, 3'b011, 1'b0);
    stepClk();
    applyStimulus(1'b0, 3'b000, 1'b0);
    stepClk();
    expectCtrl("st_exec", 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    stepClk();
    bus.mem_ack = 1'b0;
    expectCtrl("st_mem0", 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl("st_mem1", 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mem_ack = 1'b1;
    stepClk();
    bus.mem_ack = 1'b0;
    expectCtrl("st_idle", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal opcode with instr_valid held while busy
    applyStimulus(1'b1, 3'b110, 1'b0);
    stepClk();
    expectCtrl("ill_decode", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClk();
    expectCtrl("ill_idle",   1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 1'b0);
    stepClk();
    expectCtrl("ill_after",  1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef UC_TIMEOUT_EN
    // LD never acknowledged: abort after TB_TIMEOUT MEM cycles
    applyStimulus(1'b1, 3'b100, 1'b0);
    stepClk();
    applyStimulus(1'b0, 3'b000, 1'b0);
    stepClk();
    stepClk();
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      expectCtrl($sformatf("tmo_mem%0d", i), 1'b0, 1'b1, 4'h2, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b0);
      stepClk();
    end
    expectCtrl("tmo_idle",  1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    stepClk();
    expectCtrl("tmo_after", 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of an ST access
    applyStimulus(1'b1, 3'b011, 1'b0);
    stepClk();
    applyStimulus(1'b0, 3'b000, 1'b0);
    stepClk();
    stepClk();
    expectCtrl("rst_st_mem", 1'b0, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expectCtrl("rst_async",  1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    stepClk();
    runAluOp("add_after_rst", 3'b000, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
